// File: rtl/alu3_pkg.sv
// Shared encodings for the 3-bit ALU command driver: command opcodes, ALU pin
// encodings, the per-command pin mapping table and the driver FSM states.
package alu3_pkg;

  typedef enum logic [1:0] {
    ALU3_ADD = 2'd0,
    ALU3_SUB = 2'd1,
    ALU3_AND = 2'd2,
    ALU3_XOR = 2'd3
  } alu3_cmd_e;

  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_XOR   = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic       b_inv;
    logic       cin;
    logic       x;
  } alu3_pins_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } alu3_state_e;

  // SUB is a + ~b + 1 through the adder; X only enables overflow for arithmetic.
  function automatic alu3_pins_t alu3_map(input logic [1:0] cmd);
    alu3_pins_t p;
    case (alu3_cmd_e'(cmd))
      ALU3_ADD: p = '{op: OP_ARITH, b_inv: 1'b0, cin: 1'b0, x: 1'b1};
      ALU3_SUB: p = '{op: OP_ARITH, b_inv: 1'b1, cin: 1'b1, x: 1'b1};
      ALU3_AND: p = '{op: OP_AND,   b_inv: 1'b0, cin: 1'b0, x: 1'b0};
      default:  p = '{op: OP_XOR,   b_inv: 1'b0, cin: 1'b0, x: 1'b0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/alu3_ref_model.sv
// Combinational reference for the 3-bit ALU: expected result and overflow
// for a command opcode and two operands (mod-8 arithmetic).
module alu3_ref_model
  import alu3_pkg::*;
(
  input  logic [1:0] op,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] exp_res,
  output logic       exp_ovf
);

  always_comb begin
    exp_res = '0;
    exp_ovf = 1'b0;
    case (alu3_cmd_e'(op))
      ALU3_ADD: begin
        exp_res = a + b;
        exp_ovf = (a[2] == b[2]) && (exp_res[2] != a[2]);
      end
      ALU3_SUB: begin
        exp_res = a + ~b + 3'd1;
        exp_ovf = (a[2] != b[2]) && (exp_res[2] != a[2]);
      end
      ALU3_AND: exp_res = a & b;
      default:  exp_res = a ^ b;
    endcase
  end

endmodule

// File: rtl/alu3_cmd_driver.sv
// Initiator for the 3-bit ALU: accepts one command, drives registered ALU pins,
// waits SETTLE_CYCLES edges, samples the ALU and returns a checked response.
module alu3_cmd_driver
  import alu3_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          CHECK_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_b_inv,
  output logic       alu_cin,
  output logic       alu_x,
  input  logic [2:0] alu_result,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_result,
  output logic       rsp_ovf,
  output logic       rsp_mismatch,
  output logic [7:0] err_count
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  alu3_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rdy_en_q;
  logic [1:0]  cop_q, cop_d;
  logic [2:0]  a_q, a_d, b_q, b_d;
  alu3_pins_t  pins_q, pins_d;
  logic        valid_q, valid_d;
  logic [2:0]  res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        mm_q, mm_d;
  logic [7:0]  err_q, err_d;
  logic [2:0]  exp_res;
  logic        exp_ovf;

  alu3_ref_model u_ref (
    .op     (cop_q),
    .a      (a_q),
    .b      (b_q),
    .exp_res(exp_res),
    .exp_ovf(exp_ovf)
  );

  // rdy_en_q keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = rdy_en_q && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cop_d   = cop_q;
    a_d     = a_q;
    b_d     = b_q;
    pins_d  = pins_q;
    valid_d = valid_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    mm_d    = mm_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pins_d  = alu3_map(cmd_op);
          cop_d   = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = alu_result;
          ovf_d   = alu_ovf;
          mm_d    = CHECK_EN && ({alu_ovf, alu_result} != {exp_ovf, exp_res});
          valid_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          if (mm_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      cop_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pins_q   <= '0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      mm_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      cop_q    <= cop_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pins_q   <= pins_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = pins_q.op;
  assign alu_b_inv    = pins_q.b_inv;
  assign alu_cin      = pins_q.cin;
  assign alu_x        = pins_q.x;
  assign rsp_valid    = valid_q;
  assign rsp_result   = res_q;
  assign rsp_ovf      = ovf_q;
  assign rsp_mismatch = mm_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_alu3_cmd_driver.sv
// Scoreboard bench for alu3_cmd_driver with an attached behavioural 3-bit ALU
// and a signed-integer reference for expected results.
module tb_alu3_cmd_driver;

  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_a = '0;
  logic [2:0] cmd_b = '0;
  logic [2:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic       alu_b_inv, alu_cin, alu_x;
  logic [2:0] alu_result;
  logic       alu_ovf;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [2:0] rsp_result;
  logic       rsp_ovf, rsp_mismatch;
  logic [7:0] err_count;

  logic fault = 1'b0;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int err_exp = 0;
  int l_res, l_ovf, l_mm;

  typedef struct {
    int res;
    int ovf;
    int mm;
    int unsigned acc_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu3_cmd_driver #(.SETTLE_CYCLES(SETTLE), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_b_inv(alu_b_inv),
    .alu_cin(alu_cin), .alu_x(alu_x), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ovf(rsp_ovf), .rsp_mismatch(rsp_mismatch), .err_count(err_count)
  );

  // Stand-in for the physical ALU, driven only by the pins; fault forces zero outputs.
  logic [2:0] eff_b;
  logic [3:0] sum;
  always_comb begin
    eff_b      = alu_b_inv ? ~alu_b : alu_b;
    sum        = {1'b0, alu_a} + {1'b0, eff_b} + {3'b0, alu_cin};
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_result = sum[2:0];
        alu_ovf    = alu_x && (alu_a[2] == eff_b[2]) && (sum[2] != alu_a[2]);
      end
      2'b10:   alu_result = alu_a & alu_b;
      2'b11:   alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    if (fault) begin
      alu_result = '0;
      alu_ovf    = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_calc(input int op, input int a, input int b,
                                   output int res, output int ovf);
    int sa, sb_, s;
    sa  = (a > 3) ? a - 8 : a;
    sb_ = (b > 3) ? b - 8 : b;
    res = 0;
    ovf = 0;
    case (op)
      0: begin s = sa + sb_; res = ((s % 8) + 8) % 8; ovf = (s > 3 || s < -4) ? 1 : 0; end
      1: begin s = sa - sb_; res = ((s % 8) + 8) % 8; ovf = (s > 3 || s < -4) ? 1 : 0; end
      2: res = a & b;
      default: res = a ^ b;
    endcase
  endfunction

  function automatic logic [4:0] pins_exp(input int op);
    case (op)
      0:       return 5'b00_0_0_1;
      1:       return 5'b00_1_1_1;
      2:       return 5'b10_0_0_0;
      default: return 5'b11_0_0_0;
    endcase
  endfunction

  // Monitor: every rising rsp_valid must match the oldest outstanding expectation.
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && !pv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected got response %0d with no command outstanding", rsp_result);
        end else begin
          e = sb.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_ovf", rsp_ovf, e.ovf);
          chk("rsp_mismatch", rsp_mismatch, e.mm);
          chk("rsp_latency", cyc - e.acc_cyc, SETTLE);
        end
      end
      pv = rsp_valid;
    end
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input int op, input int a, input int b, input bit flt);
    int n, res, ovf;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout got 0 expected 1");
      return;
    end
    ref_calc(op, a, b, res, ovf);
    fault     = flt;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_a     = 3'(a);
    cmd_b     = 3'(b);
    l_res = flt ? 0 : res;
    l_ovf = flt ? 0 : ovf;
    l_mm  = (flt && (res != 0 || ovf != 0)) ? 1 : 0;
    @(posedge clk);
    #1;
    e.res = l_res; e.ovf = l_ovf; e.mm = l_mm; e.acc_cyc = cyc;
    sb.push_back(e);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_a     = 3'($urandom);
    cmd_b     = 3'($urandom);
    @(negedge clk);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_pins", {alu_op, alu_b_inv, alu_cin, alu_x}, pins_exp(op));
  endtask

  // Waits for the response, stalls it for hold cycles, then handshakes.
  task automatic finish_rsp(input int hold, input bit busy_cmd);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got 0 expected 1");
      return;
    end
    if (busy_cmd) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom);
      cmd_a     = 3'($urandom);
      cmd_b     = 3'($urandom);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp", {rsp_result, rsp_ovf, rsp_mismatch}, {3'(l_res), 1'(l_ovf), 1'(l_mm)});
    end
    rsp_ready = 1'b1;
    if (l_mm != 0 && err_exp < 255) err_exp++;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("err_count", err_count, err_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outputs", {alu_a, alu_b, alu_op, alu_b_inv, alu_cin, alu_x,
                        rsp_valid, rsp_result, rsp_ovf, rsp_mismatch, err_count}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);

    send_cmd(0, 1, 2, 1'b0); finish_rsp(0, 1'b0);
    send_cmd(0, 3, 2, 1'b0); finish_rsp(1, 1'b0);
    send_cmd(1, 4, 1, 1'b0); finish_rsp(0, 1'b0);
    send_cmd(1, 2, 3, 1'b0); finish_rsp(2, 1'b0);
    send_cmd(2, 6, 3, 1'b0); finish_rsp(0, 1'b0);
    send_cmd(3, 5, 3, 1'b0); finish_rsp(0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      send_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
      finish_rsp(int'($urandom_range(0, 3)), 1'b0);
    end

    for (int i = 0; i < 300; i++) begin
      send_cmd(0, 1, 2, 1'b1);
      finish_rsp(0, 1'b0);
    end
    fault = 1'b0;

    send_cmd(1, 7, 4, 1'b0);
    finish_rsp(5, 1'b1);
    send_cmd(0, 2, 2, 1'b0);
    finish_rsp(0, 1'b0);

    send_cmd(0, 3, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    err_exp = 0;
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_outputs", {alu_a, alu_b, alu_op, alu_b_inv, alu_cin, alu_x,
                           rsp_valid, rsp_result, rsp_ovf, rsp_mismatch, err_count}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_rsp_valid", rsp_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_cmd_ready", cmd_ready, 1);
    chk("midrst_rel_rsp_valid", rsp_valid, 0);
    send_cmd(0, 1, 1, 1'b0);
    finish_rsp(0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
